// File: rtl/floo_axis_link_arbiter.sv
// Shares one AXI-Stream link between the req and rsp flit channels.
// A header bit in each beat tags the channel. Round-robin arbitration with a
// bounded burst keeps either channel from starving. The link outputs are registered.
module floo_axis_link_arbiter #(
    parameter int unsigned DataWidth = 64,
    parameter int unsigned MaxBurst  = 4,
    parameter bit          RspFirst  = 1'b0
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 req_valid_i,
    output logic                 req_ready_o,
    input  logic [DataWidth-1:0] req_data_i,
    input  logic                 rsp_valid_i,
    output logic                 rsp_ready_o,
    input  logic [DataWidth-1:0] rsp_data_i,
    output logic                 axis_tvalid_o,
    input  logic                 axis_tready_i,
    output logic [DataWidth:0]   axis_tdata_o,
    output logic                 owner_o
);

    localparam int unsigned CntWidth = $clog2(MaxBurst + 1);
    localparam logic [CntWidth-1:0] CntMax = CntWidth'(MaxBurst);
    localparam logic [CntWidth-1:0] CntOne = CntWidth'(1);

    logic                 r_tvalid;
    logic [DataWidth:0]   r_tdata;
    logic                 r_owner;
    logic [CntWidth-1:0]  r_count;

    logic                 w_load_en;
    logic                 w_gnt_req;
    logic                 w_gnt_rsp;
    logic                 w_xfer;
    logic                 w_gnt_ch;
    logic [DataWidth-1:0] w_gnt_data;
    logic [CntWidth-1:0]  w_next_count;

    // Output register may load when it is empty or its beat is leaving this cycle
    assign w_load_en = !r_tvalid || axis_tready_i;

    // Grant: a lone requester always wins; under contention the owner keeps the
    // link until its burst budget runs out, then the other channel takes over
    always_comb begin
        w_gnt_req = 1'b0;
        w_gnt_rsp = 1'b0;
        if (req_valid_i && rsp_valid_i) begin
            if (r_count < CntMax) begin
                w_gnt_req = !r_owner;
                w_gnt_rsp = r_owner;
            end else begin
                w_gnt_req = r_owner;
                w_gnt_rsp = !r_owner;
            end
        end else begin
            w_gnt_req = req_valid_i;
            w_gnt_rsp = rsp_valid_i;
        end
    end

    assign req_ready_o = w_load_en && w_gnt_req;
    assign rsp_ready_o = w_load_en && w_gnt_rsp;
    assign w_xfer      = req_ready_o || rsp_ready_o;
    assign w_gnt_ch    = w_gnt_rsp;
    assign w_gnt_data  = w_gnt_rsp ? rsp_data_i : req_data_i;

    // Burst count: extend the owner's run (saturating) or restart it for a new owner
    always_comb begin
        w_next_count = CntOne;
        if (w_gnt_ch == r_owner) begin
            w_next_count = (r_count < CntMax) ? (r_count + CntOne) : r_count;
        end
    end

    // Link register, owner and burst count
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_tvalid <= 1'b0;
            r_tdata  <= '0;
            r_owner  <= RspFirst;
            r_count  <= '0;
        end else if (w_load_en) begin
            if (w_xfer) begin
                r_tvalid <= 1'b1;
                r_tdata  <= {w_gnt_ch, w_gnt_data};
                r_owner  <= w_gnt_ch;
                r_count  <= w_next_count;
            end else begin
                r_tvalid <= 1'b0;
            end
        end
    end

    assign axis_tvalid_o = r_tvalid;
    assign axis_tdata_o  = r_tdata;
    assign owner_o       = r_owner;

    // Sanity checks on configuration and the one-grant-per-cycle property
    always @(posedge clk_i) begin
        if (rst_ni) begin
            assert (MaxBurst >= 1)
                else $error("floo_axis_link_arbiter: MaxBurst must be >= 1");
            assert (!(req_ready_o && rsp_ready_o))
                else $error("floo_axis_link_arbiter: both readys high");
        end
    end

endmodule

// File: tb/tb_floo_axis_link_arbiter.sv
// Bench for floo_axis_link_arbiter: two instances (MaxBurst=4/RspFirst=0 and
// MaxBurst=1/RspFirst=1) checked every cycle against a grant-history model.
module tb_floo_axis_link_arbiter;

    localparam int unsigned DW = 16;

    logic          clk_i  = 1'b0;
    logic          rst_ni = 1'b1;
    logic          req_valid [2];
    logic          rsp_valid [2];
    logic          req_ready [2];
    logic          rsp_ready [2];
    logic [DW-1:0] req_data  [2];
    logic [DW-1:0] rsp_data  [2];
    logic          tvalid    [2];
    logic          tready    [2];
    logic [DW:0]   tdata     [2];
    logic          owner     [2];

    always #5 clk_i = ~clk_i;

    floo_axis_link_arbiter #(.DataWidth(DW), .MaxBurst(4), .RspFirst(1'b0)) dut0 (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .req_valid_i(req_valid[0]), .req_ready_o(req_ready[0]), .req_data_i(req_data[0]),
        .rsp_valid_i(rsp_valid[0]), .rsp_ready_o(rsp_ready[0]), .rsp_data_i(rsp_data[0]),
        .axis_tvalid_o(tvalid[0]), .axis_tready_i(tready[0]), .axis_tdata_o(tdata[0]),
        .owner_o(owner[0])
    );

    floo_axis_link_arbiter #(.DataWidth(DW), .MaxBurst(1), .RspFirst(1'b1)) dut1 (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .req_valid_i(req_valid[1]), .req_ready_o(req_ready[1]), .req_data_i(req_data[1]),
        .rsp_valid_i(rsp_valid[1]), .rsp_ready_o(rsp_ready[1]), .rsp_data_i(rsp_data[1]),
        .axis_tvalid_o(tvalid[1]), .axis_tready_i(tready[1]), .axis_tdata_o(tdata[1]),
        .owner_o(owner[1])
    );

    int          total = 0;
    int          bad   = 0;
    int          mb [2] = '{4, 1};
    int          rf [2] = '{0, 1};

    // Model: owner = last granted channel, burst count = length of the trailing
    // run of grants to that channel (capped); link register mirrored separately
    int          hist [2][$];
    bit          m_tvalid [2];
    logic [DW:0] m_tdata  [2];

    logic [DW-1:0] src [2][2][$];
    logic [DW:0]   sb  [2][$];
    bit            hlog [2][$];
    bit            en [2][2];
    bit            rand_tr = 1'b0;
    bit            rand_en = 1'b0;

    task automatic chk(input string tag, input int k, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s dut%0d observed=%0h expected=%0h", tag, k, obs, exp);
        end
    endtask

    function automatic int owner_of(int k);
        return (hist[k].size() > 0) ? hist[k][hist[k].size()-1] : rf[k];
    endfunction

    function automatic int run_len(int k);
        int n = 0;
        int o = owner_of(k);
        for (int i = hist[k].size() - 1; i >= 0; i--) begin
            if (hist[k][i] != o) break;
            n++;
        end
        return (n > mb[k]) ? mb[k] : n;
    endfunction

    function automatic int model_grant(int k, bit rv, bit sv);
        if (rv && !sv) return 0;
        if (sv && !rv) return 1;
        if (!rv && !sv) return -1;
        return (run_len(k) < mb[k]) ? owner_of(k) : 1 - owner_of(k);
    endfunction

    // One clock: drive at posedge+1, check at negedge, advance model at posedge
    task automatic cycle();
        int   g    [2];
        bit   load [2];
        logic [DW-1:0] d;
        for (int k = 0; k < 2; k++) begin
            if (rand_tr) tready[k] = ($urandom_range(0, 3) != 0);
            if (rand_en) begin
                en[k][0] = ($urandom_range(0, 9) < 7);
                en[k][1] = ($urandom_range(0, 9) < 7);
            end
            req_valid[k] = en[k][0] && (src[k][0].size() > 0);
            rsp_valid[k] = en[k][1] && (src[k][1].size() > 0);
            req_data[k]  = (src[k][0].size() > 0) ? src[k][0][0] : '0;
            rsp_data[k]  = (src[k][1].size() > 0) ? src[k][1][0] : '0;
        end
        @(negedge clk_i);
        for (int k = 0; k < 2; k++) begin
            g[k]    = model_grant(k, req_valid[k], rsp_valid[k]);
            load[k] = !m_tvalid[k] || tready[k];
            chk("req_ready", k, 64'(req_ready[k]), 64'(load[k] && g[k] == 0));
            chk("rsp_ready", k, 64'(rsp_ready[k]), 64'(load[k] && g[k] == 1));
            chk("tvalid",    k, 64'(tvalid[k]),    64'(m_tvalid[k]));
            chk("tdata",     k, 64'(tdata[k]),     64'(m_tdata[k]));
            chk("owner",     k, 64'(owner[k]),     64'(owner_of(k)));
            if (tvalid[k] === 1'b1 && tready[k]) begin
                if (sb[k].size() == 0) begin
                    chk("sb_unexpected_beat", k, 64'(tdata[k]), 64'hFFFF_FFFF_FFFF_FFFF);
                end else begin
                    chk("sb_beat", k, 64'(tdata[k]), 64'(sb[k].pop_front()));
                end
                hlog[k].push_back(tdata[k][DW]);
            end
        end
        @(posedge clk_i);
        for (int k = 0; k < 2; k++) begin
            if (load[k]) begin
                if (g[k] >= 0) begin
                    d = src[k][g[k]].pop_front();
                    m_tdata[k]  = {1'(g[k]), d};
                    m_tvalid[k] = 1'b1;
                    sb[k].push_back(m_tdata[k]);
                    hist[k].push_back(g[k]);
                    while (hist[k].size() > mb[k] + 1) void'(hist[k].pop_front());
                end else begin
                    m_tvalid[k] = 1'b0;
                end
            end
        end
        #1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    // Async reset: outputs must clear before any clock edge
    task automatic do_reset();
        rst_ni = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            chk("rst_tvalid", k, 64'(tvalid[k]), 64'(0));
            chk("rst_tdata",  k, 64'(tdata[k]),  64'(0));
            chk("rst_owner",  k, 64'(owner[k]),  64'(rf[k]));
            hist[k].delete();
            sb[k].delete();
            hlog[k].delete();
            src[k][0].delete();
            src[k][1].delete();
            m_tvalid[k]  = 1'b0;
            m_tdata[k]   = '0;
            en[k][0]     = 1'b0;
            en[k][1]     = 1'b0;
            req_valid[k] = 1'b0;
            rsp_valid[k] = 1'b0;
            tready[k]    = 1'b1;
        end
        rand_tr = 1'b0;
        rand_en = 1'b0;
        @(negedge clk_i);
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            req_valid[k] = 1'b0; rsp_valid[k] = 1'b0;
            req_data[k]  = '0;   rsp_data[k]  = '0;
            tready[k]    = 1'b1;
        end
        #2;
        do_reset();

        // Lone req channel streams 10 flits back to back
        for (int i = 0; i < 10; i++) src[0][0].push_back(DW'(i));
        en[0][0] = 1'b1;
        run(14);
        chk("t1_beats", 0, 64'(hlog[0].size()), 64'(10));

        // Continuous contention: bursts of 4 (dut0) and strict alternation (dut1)
        do_reset();
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 12; i++) begin
                src[k][0].push_back(DW'($urandom));
                src[k][1].push_back(DW'($urandom));
            end
            en[k][0] = 1'b1;
            en[k][1] = 1'b1;
        end
        run(28);
        for (int i = 0; i < 12; i++) begin
            chk("t2_hdr_seq", 0, 64'(hlog[0][i]), 64'((i / 4) % 2));
            chk("t3_hdr_seq", 1, 64'(hlog[1][i]), 64'((i % 2) == 0));
        end

        // Link stall for 5 cycles with a beat pending, then release
        do_reset();
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 4; i++) src[k][0].push_back(DW'($urandom));
            src[k][1].push_back(DW'($urandom));
            en[k][0] = 1'b1;
            en[k][1] = 1'b1;
        end
        run(1);
        tready[0] = 1'b0;
        tready[1] = 1'b0;
        run(5);
        tready[0] = 1'b1;
        tready[1] = 1'b1;
        run(8);

        // Req streams 6 beats; a rsp flit appears after 2 req grants
        do_reset();
        for (int i = 0; i < 6; i++) src[0][0].push_back(DW'(16'h100 + i));
        en[0][0] = 1'b1;
        en[0][1] = 1'b1;
        run(2);
        src[0][1].push_back(DW'(16'hBEEF));
        run(10);
        begin
            bit exp_seq [7] = '{0, 0, 0, 0, 1, 0, 0};
            chk("t5_beats", 0, 64'(hlog[0].size()), 64'(7));
            for (int i = 0; i < 7 && i < hlog[0].size(); i++)
                chk("t5_hdr_seq", 0, 64'(hlog[0][i]), 64'(exp_seq[i]));
        end

        // Random traffic and backpressure
        do_reset();
        rand_tr = 1'b1;
        rand_en = 1'b1;
        for (int c = 0; c < 400; c++) begin
            for (int k = 0; k < 2; k++)
                for (int ch = 0; ch < 2; ch++)
                    if (src[k][ch].size() < 3 && $urandom_range(0, 1) == 1)
                        src[k][ch].push_back(DW'($urandom));
            cycle();
        end
        rand_tr = 1'b0;
        rand_en = 1'b0;
        for (int k = 0; k < 2; k++) begin
            tready[k] = 1'b1;
            en[k][0]  = 1'b1;
            en[k][1]  = 1'b1;
        end
        run(16);
        for (int k = 0; k < 2; k++) begin
            chk("drain_src", k, 64'(src[k][0].size() + src[k][1].size()), 64'(0));
            chk("drain_sb",  k, 64'(sb[k].size()), 64'(0));
        end

        // Reset mid-burst, then first contention must go to the preferred channel
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 6; i++) src[k][0].push_back(DW'($urandom));
        end
        run(3);
        chk("t6_pre_tvalid", 0, 64'(tvalid[0]), 64'(1));
        do_reset();
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 3; i++) begin
                src[k][0].push_back(DW'($urandom));
                src[k][1].push_back(DW'($urandom));
            end
            en[k][0] = 1'b1;
            en[k][1] = 1'b1;
        end
        run(4);
        chk("t6_first_hdr", 0, 64'(hlog[0].size() > 0 ? hlog[0][0] : 1'bx), 64'(0));
        chk("t6_first_hdr", 1, 64'(hlog[1].size() > 0 ? hlog[1][0] : 1'bx), 64'(1));
        run(8);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
